// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the 5-stage MIPS-style core: ALU operation codes,
// bit positions of the EX control field, multiply/divide op codes, forwarding
// select codes, the multiply/divide FSM state type and a magnitude helper.
// ----------------------------------------------------------------------------
package core_pkg;

  localparam int XLEN = 32;

  // ALU operation codes (EX[3:0])
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_LUI  = 4'b1101;

  // EX control field layout
  localparam int EX_ALU_OP_LSB = 0;
  localparam int EX_ALU_OP_MSB = 3;
  localparam int EX_ALU_SRC    = 4;
  localparam int EX_REG_DST    = 5;
  localparam int EX_RSVD_LSB   = 6;
  localparam int EX_RSVD_MSB   = 7;
  localparam int EX_MD_LSB     = 8;
  localparam int EX_MD_MSB     = 9;

  typedef enum logic [1:0] {
    MD_NONE   = 2'b00,
    MD_MULT   = 2'b01,
    MD_DIV    = 2'b10,
    MD_MFHILO = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    FWD_REG     = 2'b00,
    FWD_MEM     = 2'b01,
    FWD_WB      = 2'b10,
    FWD_REG_ALT = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  // Absolute value of a two's complement word; -2^31 maps to 2^31 unsigned.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
// Iterative signed multiply (shift-add) and divide (restoring) with HI/LO.
// Both operate on operand magnitudes, one bit per BUSY cycle, and apply the
// signs when the result is committed to HI/LO.
//
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset
//   start          : request an operation (honoured only in IDLE)
//   op             : md_op code, MD_DIV selects divide, anything else multiply
//   a, b           : operands (dividend/divisor for divide)
//   busy           : high for the start cycle and every BUSY cycle
//   done           : high for the single DONE cycle
//   hi, lo         : HI/LO registers
// ----------------------------------------------------------------------------
module muldiv_unit
  import core_pkg::*;
#(
  parameter int MD_CYCLES = 32  // must equal XLEN: one result bit per cycle
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  hi,
  output logic [XLEN-1:0]  lo
);

  localparam int CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mag_q, mag_d;        // |multiplicand| or |divisor|
  logic              is_div_q, is_div_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic              div0_q, div0_d;
  logic [XLEN-1:0]   dividend_q, dividend_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;

  // Reset gates the start request so the stall output drops while reset_n is low.
  logic start_ok;
  assign start_ok = start & reset_n;

  // One iteration of either algorithm.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] step;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_sh - {1'b0, mag_q};
    if (is_div_q) begin
      // Restoring step: keep the subtraction only when it did not go negative.
      step = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                            : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Signed results from the final iteration.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   fin_hi, fin_lo;

  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    prod   = (sign_a_q ^ sign_b_q) ? (~step + 1'b1) : step;
    fin_hi = prod[2*XLEN-1:XLEN];
    fin_lo = prod[XLEN-1:0];
    if (is_div_q) begin
      if (div0_q) begin
        fin_hi = dividend_q;
        fin_lo = '1;
      end else begin
        // Quotient truncates toward zero; remainder follows the dividend sign.
        fin_lo = (sign_a_q ^ sign_b_q) ? (~step[XLEN-1:0] + 1'b1) : step[XLEN-1:0];
        fin_hi = sign_a_q ? (~step[2*XLEN-1:XLEN] + 1'b1) : step[2*XLEN-1:XLEN];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mag_d      = mag_q;
    is_div_d   = is_div_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    div0_d     = div0_q;
    dividend_d = dividend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    unique case (state_q)
      MD_IDLE: begin
        if (start_ok) begin
          is_div_d   = (op == MD_DIV);
          sign_a_d   = a[XLEN-1];
          sign_b_d   = b[XLEN-1];
          div0_d     = (b == '0);
          dividend_d = a;
          mag_d      = (op == MD_DIV) ? mag(b) : mag(a);
          acc_d      = {{XLEN{1'b0}}, ((op == MD_DIV) ? mag(a) : mag(b))};
          cnt_d      = '0;
          state_d    = MD_BUSY;
        end
      end
      MD_BUSY: begin
        acc_d = step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          hi_d    = fin_hi;
          lo_d    = fin_lo;
          cnt_d   = '0;
          state_d = MD_DONE;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mag_q      <= '0;
      is_div_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div0_q     <= 1'b0;
      dividend_q <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mag_q      <= mag_d;
      is_div_q   <= is_div_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      div0_q     <= div0_d;
      dividend_q <= dividend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy = ((state_q == MD_IDLE) && start_ok) || (state_q == MD_BUSY);
  assign done = (state_q == MD_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage
// Execute stage plus EX/MEM pipeline register. Selects forwarded operands,
// evaluates the ALU, branch target and zero flag, drives the multiply/divide
// unit and registers the result for MEM. Multiply/divide occupancy and flushes
// load a bubble (all EX/MEM outputs zero).
//
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   WB[1:0], M[2:0], EX[9:0]: control from ID/EX
//   regRs, regRt, imm_value, PC : operands, sign-extended immediate, PC+4
//   addrRt, addrRd          : destination candidates
//   fwd_a, fwd_b            : forwarding selects; mem_fwd, wb_fwd the values
//   flush                   : squash the instruction in EX
//   ex_stall                : hold upstream stages
//   WBOut, MOut, aluOut, storeData, branchTarget, zeroOut, writeAddrOut :
//                             EX/MEM register outputs
// ----------------------------------------------------------------------------
module ex_stage
  import core_pkg::*;
#(
  parameter int WIDTH     = 32,  // only 32 is supported
  parameter int MD_CYCLES = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       WB,
  input  logic [2:0]       M,
  input  logic [9:0]       EX,
  input  logic [WIDTH-1:0] regRs,
  input  logic [WIDTH-1:0] regRt,
  input  logic [WIDTH-1:0] imm_value,
  input  logic [WIDTH-1:0] PC,
  input  logic [4:0]       addrRt,
  input  logic [4:0]       addrRd,
  input  logic [1:0]       fwd_a,
  input  logic [1:0]       fwd_b,
  input  logic [WIDTH-1:0] mem_fwd,
  input  logic [WIDTH-1:0] wb_fwd,
  input  logic             flush,
  output logic             ex_stall,
  output logic [1:0]       WBOut,
  output logic [2:0]       MOut,
  output logic [WIDTH-1:0] aluOut,
  output logic [WIDTH-1:0] storeData,
  output logic [WIDTH-1:0] branchTarget,
  output logic             zeroOut,
  output logic [4:0]       writeAddrOut
);

  logic [3:0] alu_op;
  md_op_e     md_op;
  logic       unused_rsvd;

  assign alu_op      = EX[EX_ALU_OP_MSB:EX_ALU_OP_LSB];
  assign md_op       = md_op_e'(EX[EX_MD_MSB:EX_MD_LSB]);
  assign unused_rsvd = ^EX[EX_RSVD_MSB:EX_RSVD_LSB];

  // Forwarding and operand selection
  logic [WIDTH-1:0] op_a, fwd_b_val, op_b;
  logic [4:0]       shamt;

  always_comb begin
    unique case (fwd_a)
      FWD_MEM: op_a = mem_fwd;
      FWD_WB:  op_a = wb_fwd;
      default: op_a = regRs;
    endcase
    unique case (fwd_b)
      FWD_MEM: fwd_b_val = mem_fwd;
      FWD_WB:  fwd_b_val = wb_fwd;
      default: fwd_b_val = regRt;
    endcase
    op_b  = EX[EX_ALU_SRC] ? imm_value : fwd_b_val;
    shamt = imm_value[10:6];
  end

  // ALU
  logic [WIDTH-1:0] alu_res;

  always_comb begin
    unique case (alu_op)
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      ALU_NOR:  alu_res = ~(op_a | op_b);
      ALU_SLL:  alu_res = op_b << shamt;
      ALU_SRL:  alu_res = op_b >> shamt;
      ALU_SRA:  alu_res = $signed(op_b) >>> shamt;
      ALU_LUI:  alu_res = {imm_value[15:0], 16'h0000};
      default:  alu_res = '0;
    endcase
  end

  // Multiply/divide unit
  logic             md_start, md_busy, md_done;
  logic [WIDTH-1:0] md_hi, md_lo;

  assign md_start = ((md_op == MD_MULT) || (md_op == MD_DIV)) && !flush;

  muldiv_unit #(
    .MD_CYCLES (MD_CYCLES)
  ) u_muldiv (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (md_start),
    .op      (EX[EX_MD_MSB:EX_MD_LSB]),
    .a       (op_a),
    .b       (fwd_b_val),
    .busy    (md_busy),
    .done    (md_done),
    .hi      (md_hi),
    .lo      (md_lo)
  );

  assign ex_stall = md_busy;

  // EX/MEM register. The multiply/divide occupancy (start, BUSY, DONE) and a
  // flush all load a bubble; flush cannot cancel an operation already running.
  logic             bubble;
  logic [1:0]       wb_q, wb_d;
  logic [2:0]       m_q, m_d;
  logic [WIDTH-1:0] alu_q, alu_d;
  logic [WIDTH-1:0] store_q, store_d;
  logic [WIDTH-1:0] btgt_q, btgt_d;
  logic             zero_q, zero_d;
  logic [4:0]       waddr_q, waddr_d;

  assign bubble = flush | md_busy | md_done;

  always_comb begin
    wb_d    = '0;
    m_d     = '0;
    alu_d   = '0;
    store_d = '0;
    btgt_d  = '0;
    zero_d  = 1'b0;
    waddr_d = '0;
    if (!bubble) begin
      wb_d    = WB;
      m_d     = M;
      alu_d   = (md_op == MD_MFHILO) ? (alu_op[0] ? md_hi : md_lo) : alu_res;
      store_d = fwd_b_val;
      btgt_d  = PC + {imm_value[WIDTH-3:0], 2'b00};
      zero_d  = ((op_a - op_b) == '0);
      waddr_d = EX[EX_REG_DST] ? addrRd : addrRt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_q    <= '0;
      m_q     <= '0;
      alu_q   <= '0;
      store_q <= '0;
      btgt_q  <= '0;
      zero_q  <= 1'b0;
      waddr_q <= '0;
    end else begin
      wb_q    <= wb_d;
      m_q     <= m_d;
      alu_q   <= alu_d;
      store_q <= store_d;
      btgt_q  <= btgt_d;
      zero_q  <= zero_d;
      waddr_q <= waddr_d;
    end
  end

  assign WBOut        = wb_q;
  assign MOut         = m_q;
  assign aluOut       = alu_q;
  assign storeData    = store_q;
  assign branchTarget = btgt_q;
  assign zeroOut      = zero_q;
  assign writeAddrOut = waddr_q;

endmodule

// File: tb/tb_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_stage
// Self-checking bench for ex_stage: directed cases plus randomized ALU and
// multiply/divide traffic compared against a behavioural model (plain integer
// arithmetic for the ALU, 64-bit multiply and integer divide for HI/LO).
// ----------------------------------------------------------------------------
module tb_ex_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  WB;
  logic [2:0]  M;
  logic [9:0]  EX;
  logic [31:0] regRs, regRt, imm_value, PC;
  logic [4:0]  addrRt, addrRd;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] mem_fwd, wb_fwd;
  logic        flush;
  logic        ex_stall;
  logic [1:0]  WBOut;
  logic [2:0]  MOut;
  logic [31:0] aluOut, storeData, branchTarget;
  logic        zeroOut;
  logic [4:0]  writeAddrOut;

  int n_vec = 0;
  int n_bad = 0;

  // Model of HI/LO
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always #5 clock = ~clock;

  ex_stage dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .WB           (WB),
    .M            (M),
    .EX           (EX),
    .regRs        (regRs),
    .regRt        (regRt),
    .imm_value    (imm_value),
    .PC           (PC),
    .addrRt       (addrRt),
    .addrRd       (addrRd),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .mem_fwd      (mem_fwd),
    .wb_fwd       (wb_fwd),
    .flush        (flush),
    .ex_stall     (ex_stall),
    .WBOut        (WBOut),
    .MOut         (MOut),
    .aluOut       (aluOut),
    .storeData    (storeData),
    .branchTarget (branchTarget),
    .zeroOut      (zeroOut),
    .writeAddrOut (writeAddrOut)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] r,
                                       input logic [31:0] m, input logic [31:0] w);
    if (sel == 2'b01) return m;
    if (sel == 2'b10) return w;
    return r;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
    int unsigned sh;
    longint      sb;
    sh = imm[10:6];
    sb = $signed(b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1011: return (a < b) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      4'b1000: return 32'(64'(b) * (64'd1 << sh));
      4'b1001: return 32'(64'(b) / (64'd1 << sh));
      4'b1010: return 32'(sb >>> sh);
      4'b1101: return imm * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, ex_stall, 0);
    check({tag, "_wb"}, WBOut, 0);
    check({tag, "_m"}, MOut, 0);
    check({tag, "_alu"}, aluOut, 0);
    check({tag, "_store"}, storeData, 0);
    check({tag, "_btgt"}, branchTarget, 0);
    check({tag, "_zero"}, zeroOut, 0);
    check({tag, "_waddr"}, writeAddrOut, 0);
  endtask

  // Single-cycle instruction: model the expected EX/MEM contents from the
  // currently driven inputs, clock once and compare.
  task automatic step_and_check(input string tag);
    logic [31:0] a, fb, b, e_alu, e_store, e_bt;
    logic        e_zero;
    logic [4:0]  e_wa;
    logic [1:0]  e_wb;
    logic [2:0]  e_m;
    a  = pick(fwd_a, regRs, mem_fwd, wb_fwd);
    fb = pick(fwd_b, regRt, mem_fwd, wb_fwd);
    b  = EX[4] ? imm_value : fb;
    if (EX[9:8] == 2'b11) e_alu = EX[0] ? m_hi : m_lo;
    else                  e_alu = ref_alu(EX[3:0], a, b, imm_value);
    e_store = fb;
    e_bt    = PC + imm_value * 32'd4;
    e_zero  = (a == b);
    e_wa    = EX[5] ? addrRd : addrRt;
    e_wb    = WB;
    e_m     = M;
    if (flush) begin
      e_alu = 0; e_store = 0; e_bt = 0; e_zero = 0; e_wa = 0; e_wb = 0; e_m = 0;
    end
    #1;
    check({tag, "_stall"}, ex_stall, 0);
    @(posedge clock);
    #1;
    check({tag, "_wb"}, WBOut, e_wb);
    check({tag, "_m"}, MOut, e_m);
    check({tag, "_alu"}, aluOut, e_alu);
    check({tag, "_store"}, storeData, e_store);
    check({tag, "_btgt"}, branchTarget, e_bt);
    check({tag, "_zero"}, zeroOut, e_zero);
    check({tag, "_waddr"}, writeAddrOut, e_wa);
  endtask

  task automatic issue_mf(input bit sel_hi);
    EX        = {2'b11, 2'b00, 1'($urandom), 1'($urandom), 3'($urandom), sel_hi};
    WB        = 2'b10;
    M         = 3'b000;
    fwd_a     = 2'($urandom);
    fwd_b     = 2'($urandom);
    regRs     = $urandom;
    regRt     = $urandom;
    imm_value = $urandom;
    addrRt    = 5'($urandom);
    addrRd    = 5'($urandom);
    flush     = 1'b0;
  endtask

  // Multiply/divide: stall length, bubbles throughout, HI/LO model update.
  task automatic run_md(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input bit flush_mid, input string tag);
    longint      sa, sb;
    logic [31:0] e_hi, e_lo;
    int          n;
    sa = $signed(a);
    sb = $signed(b);
    if (!is_div) begin
      {e_hi, e_lo} = 64'(sa * sb);
    end else if (b == 0) begin
      e_hi = a;
      e_lo = 32'hFFFF_FFFF;
    end else begin
      e_lo = 32'(sa / sb);
      e_hi = 32'(sa % sb);
    end
    EX        = {(is_div ? 2'b10 : 2'b01), 2'b00, 1'($urandom), 1'b0, 4'($urandom)};
    WB        = 2'b11;
    M         = 3'b111;
    regRs     = a;
    regRt     = b;
    fwd_a     = 2'b00;
    fwd_b     = 2'b00;
    imm_value = $urandom;
    flush     = 1'b0;
    #1;
    n = 0;
    while (ex_stall === 1'b1 && n < 100) begin
      n++;
      if (flush_mid && n == 5) flush = 1'b1;
      @(posedge clock);
      #1;
      check({tag, "_bubble_wb"}, WBOut, 0);
      check({tag, "_bubble_m"}, MOut, 0);
    end
    check({tag, "_stall_cycles"}, n, 33);
    @(posedge clock);
    #1;
    check({tag, "_done_wb"}, WBOut, 0);
    check({tag, "_done_m"}, MOut, 0);
    flush = 1'b0;
    m_hi  = e_hi;
    m_lo  = e_lo;
  endtask

  task automatic rand_inputs();
    logic [31:0] r;
    logic [1:0]  md;
    md        = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
    EX        = {md, 2'b00, 1'($urandom), 1'($urandom), 4'($urandom)};
    WB        = 2'($urandom);
    M         = 3'($urandom);
    regRs     = $urandom;
    regRt     = ($urandom_range(0, 3) == 0) ? regRs : $urandom;
    r         = $urandom;
    imm_value = {{16{r[15]}}, r[15:0]};
    PC        = $urandom & 32'hFFFF_FFFC;
    addrRt    = 5'($urandom);
    addrRd    = 5'($urandom);
    fwd_a     = 2'($urandom);
    fwd_b     = 2'($urandom);
    mem_fwd   = ($urandom_range(0, 3) == 0) ? regRs : $urandom;
    wb_fwd    = ($urandom_range(0, 3) == 0) ? regRt : $urandom;
    flush     = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    WB = 0; M = 0; EX = 0; regRs = 0; regRt = 0; imm_value = 0; PC = 0;
    addrRt = 0; addrRd = 0; fwd_a = 0; fwd_b = 0; mem_fwd = 0; wb_fwd = 0; flush = 0;
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    // ADD rs(5) + imm(-3) -> rt 9
    EX = {2'b00, 2'b00, 1'b0, 1'b1, 4'b0010};
    regRs = 32'd5; imm_value = 32'hFFFF_FFFD; WB = 2'b10; addrRt = 5'd9; addrRd = 5'd17;
    PC = 32'h0000_1000;
    step_and_check("add");
    check("tp_add_alu", aluOut, 32'd2);
    check("tp_add_waddr", writeAddrOut, 32'd9);
    check("tp_add_wb", WBOut, 32'd2);

    // SUB with MEM forward on A, then WB forward on B
    EX = {2'b00, 2'b00, 1'b1, 1'b0, 4'b0110};
    fwd_a = 2'b01; mem_fwd = 32'd10; regRt = 32'd10; fwd_b = 2'b00; regRs = 32'd99;
    step_and_check("sub_eq");
    check("tp_sub_eq_alu", aluOut, 32'd0);
    check("tp_sub_eq_zero", zeroOut, 32'd1);
    fwd_b = 2'b10; wb_fwd = 32'd3;
    step_and_check("sub_ne");
    check("tp_sub_ne_alu", aluOut, 32'd7);
    check("tp_sub_ne_zero", zeroOut, 32'd0);

    // Flushed store
    EX = {2'b00, 2'b00, 1'b0, 1'b1, 4'b0010};
    M = 3'b001; WB = 2'b00; flush = 1'b1;
    step_and_check("flush_store");
    check("tp_flush_mout", MOut, 32'd0);
    flush = 1'b0;

    // MULT -7 * 3
    run_md(1'b0, -32'sd7, 32'sd3, 1'b0, "mult");
    issue_mf(1'b0); step_and_check("mult_mflo");
    check("tp_mult_lo", aluOut, 32'hFFFF_FFEB);
    issue_mf(1'b1); step_and_check("mult_mfhi");
    check("tp_mult_hi", aluOut, 32'hFFFF_FFFF);

    // DIV -7 / 2 and 5 / 0
    run_md(1'b1, -32'sd7, 32'sd2, 1'b0, "div");
    issue_mf(1'b0); step_and_check("div_mflo");
    check("tp_div_lo", aluOut, 32'hFFFF_FFFD);
    issue_mf(1'b1); step_and_check("div_mfhi");
    check("tp_div_hi", aluOut, 32'hFFFF_FFFF);
    run_md(1'b1, 32'd5, 32'd0, 1'b0, "div0");
    issue_mf(1'b0); step_and_check("div0_mflo");
    check("tp_div0_lo", aluOut, 32'hFFFF_FFFF);
    issue_mf(1'b1); step_and_check("div0_mfhi");
    check("tp_div0_hi", aluOut, 32'd5);

    // Flush raised while BUSY: the multiply still commits
    run_md(1'b0, 32'd1234567, -32'sd89, 1'b1, "mult_flush");
    issue_mf(1'b0); step_and_check("mflush_mflo");
    issue_mf(1'b1); step_and_check("mflush_mfhi");

    // Reset in the middle of a MULT (HI/LO currently non-zero)
    EX = {2'b01, 2'b00, 1'b0, 1'b0, 4'b0000};
    regRs = 32'd100; regRt = 32'd200; fwd_a = 0; fwd_b = 0; WB = 2'b11; M = 3'b010;
    repeat (11) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    m_hi = '0;
    m_lo = '0;
    issue_mf(1'b0);
    #2;
    reset_n = 1'b1;
    step_and_check("rst_mflo");
    check("tp_rst_lo", aluOut, 32'd0);
    issue_mf(1'b1); step_and_check("rst_mfhi");
    check("tp_rst_hi", aluOut, 32'd0);
    run_md(1'b1, -32'sd1000, 32'sd7, 1'b0, "post_reset_div");
    issue_mf(1'b0); step_and_check("prd_mflo");

    // Randomized single-cycle traffic
    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      step_and_check("rnd_alu");
    end

    // Randomized multiply/divide, including boundary operands
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i == 2) b = 32'd0;
      if (i == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (i == 4) b = {{28{b[31]}}, b[3:0]};
      run_md(1'($urandom), a, b, (i == 5), "rnd_md");
      issue_mf(1'b0); step_and_check("rnd_mflo");
      issue_mf(1'b1); step_and_check("rnd_mfhi");
      for (int j = 0; j < 3; j++) begin
        rand_inputs();
        step_and_check("rnd_mix");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage plus EX/MEM pipeline register for the 5-stage MIPS-style core. Consumes the ID/EX register outputs, applies forwarding, computes the ALU result and branch target, runs an iterative signed multiply/divide unit with HI/LO registers, and registers everything for the MEM stage. Asserts `ex_stall` while a multiply or divide is in progress so IF/ID/ID-EX hold.

## Interface
- `WIDTH`, 32: datapath width. Only 32 is supported.
- `MD_CYCLES`, 32: iterations per multiply/divide.
- `clock` in 1: the single clock. All state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `WB` in 2: WB control. `[1]` is RegWrite, `[0]` is MemToReg.
- `M` in 3: MEM control. `[2]` is Branch, `[1]` is MemRead, `[0]` is MemWrite.
- `EX` in 10: EX control.
  - `[3:0]` alu_op.
  - `[4]` alu_src: 1 selects imm for operand B.
  - `[5]` reg_dst: 1 selects rd, 0 selects rt.
  - `[7:6]` reserved, must be 0.
  - `[9:8]` md_op: 00 none, 01 MULT, 10 DIV, 11 MFHI/MFLO.
- `regRs`, `regRt`, `imm_value`, `PC` in 32: operands, sign-extended immediate, and PC+4.
- `addrRt`, `addrRd` in 5: destination candidates.
- `fwd_a`, `fwd_b` in 2: forwarding selects. 00 register, 01 `mem_fwd`, 10 `wb_fwd`, 11 register.
- `mem_fwd`, `wb_fwd` in 32: forwarded values from MEM and WB.
- `flush` in 1: squash the instruction currently in EX.
- `ex_stall` out 1: hold upstream stages.
- `WBOut` out 2, `MOut` out 3: registered controls.
- `aluOut` out 32: registered ALU or HI/LO result.
- `storeData` out 32: registered forwarded B, before the imm mux.
- `branchTarget` out 32: registered PC + (imm << 2).
- `zeroOut` out 1: registered (A − B == 0).
- `writeAddrOut` out 5: registered destination register.

## Operation
- Operand A is chosen by `fwd_a`. Forwarded B is chosen by `fwd_b`. ALU operand B is imm when `alu_src` is set, otherwise forwarded B.
- alu_op encodings:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT (signed), 1011 SLTU, 1100 NOR.
  - 1000 SLL, 1001 SRL, 1010 SRA: operate on B, shift amount is `imm_value[10:6]`.
  - 1101 LUI: imm << 16.
  - Any other encoding yields 0.
  - ADD and SUB wrap; there is no overflow trap.
- md_op 11 ignores alu_op except bit 0, which selects HI (1) or LO (0) as the result.
- MULT: signed 32×32, full 64-bit product. HI takes product[63:32], LO takes product[31:0].
- DIV: signed. LO is the quotient truncated toward zero; HI is the remainder, which has the sign of the dividend.
- Divide by zero gives HI = dividend and LO = 32'hFFFF_FFFF. No exception is raised.
- Multiply/divide FSM:
  - IDLE: when md_op ∈ {01,10} and `flush` = 0, latch A and B, assert `ex_stall` combinationally, go to BUSY with count = 0.
  - BUSY: `ex_stall` = 1, count increments each cycle. At count = MD_CYCLES−1, write HI/LO and go to DONE.
  - DONE: `ex_stall` = 0, so upstream advances at this edge. Return to IDLE.
- While the FSM is in IDLE-start, BUSY, or DONE, the EX/MEM register loads a bubble: `WBOut` = 0 and `MOut` = 0. MULT and DIV never write a GPR.
- `flush` = 1 in IDLE: load a bubble. `flush` in BUSY or DONE is ignored, because the operation commits.
- MFHI/MFLO issued in the cycle after DONE sees the new HI/LO. There is no internal forwarding hazard.

## Timing
- Non-multiply/divide instructions: one cycle. Inputs present at edge N appear on the outputs after edge N.
- MULT/DIV: `ex_stall` is high for MD_CYCLES+1 cycles (33 by default).
  - The next instruction is accepted at the edge that ends DONE.
  - Issue-to-issue spacing is 34 cycles.
- Reset (asynchronous, any state, including mid-operation):
  - FSM goes to IDLE and count to 0.
  - HI, LO and all outputs go to 0; `ex_stall` goes to 0.
  - A partial result is discarded and HI/LO are not updated.
- `branchTarget` and `zeroOut` are computed every cycle regardless of `M[2]`. They are zeroed for bubbles.

## Structure
- Shared package `core_pkg` holds:
  - alu_op constants;
  - EX field bit positions;
  - md_op encodings;
  - fwd select encodings.
- Sub-module `muldiv_unit` contains the FSM, counter, shift-add multiplier, restoring divider, and HI/LO. Its ports are start, op, a, b, busy, done, hi, lo.
- `ex_stage` contains the forwarding muxes, the ALU, and the EX/MEM register.

## Test plan
- ADD with regRs=5, imm=−3, alu_src=1, WB=2'b10, reg_dst=0, addrRt=9: next cycle `aluOut`=2, `writeAddrOut`=9, `WBOut`=2'b10.
- SUB with fwd_a=01, mem_fwd=10, regRt=10: `aluOut`=0 and `zeroOut`=1. Repeat with fwd_b=10, wb_fwd=3: `aluOut`=7 and `zeroOut`=0.
- MULT −7 × 3:
  - `ex_stall` is high for exactly 33 cycles;
  - the following MFLO returns 0xFFFF_FFEB and MFHI returns 0xFFFF_FFFF;
  - MOut and WBOut are 0 throughout.
- DIV −7 / 2 gives LO=−3 and HI=−1. DIV 5 / 0 gives LO=0xFFFF_FFFF and HI=5.
- Assert `reset_n`=0 at BUSY count 10 after a MULT with HI/LO preloaded: `ex_stall` drops immediately, HI/LO read 0, and the FSM is in IDLE.
- `flush` with a MEM store (M=001) present: `MOut`=0 next cycle. `flush` during BUSY: the MULT still completes and HI/LO are updated.
